// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore-style multicycle control FSM for the shared-memory
// MIPS datapath. It steps through fetch, decode, execute, memory access and writeback.
// It also includes an EXEC_R stall watchdog and a retired-instruction counter.
// Optional feature macro: MEMWAIT_EN adds a mem_ready input. With it, FETCH,
// MEM_RD and MEM_WR wait until memory reports ready.
module mips_multicycle_ctrl #(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic             zero,
  input  logic             stall,
`ifdef MEMWAIT_EN
  input  logic             mem_ready,
`endif
  output logic             PcEn,
  output logic             IorD,
  output logic             IrWrite,
  output logic             IrSel,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             ExtSel,
  output logic             ALUsel,
  output logic             PCSrc,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic             MemWrite,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int SC_W = $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'(MAX_STALL - 1);

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB_R, ALU_WB_I,
    MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
  } state_t;

  state_t            state_reg, state_next;
  logic [SC_W-1:0]   stall_cnt_reg, stall_cnt_next;
  logic              err_reg;
  logic [CNT_W-1:0]  retired_reg;
  logic              err_set;
  logic              retire;
  logic              mem_rdy;
  logic [5:0]        opcode;

  // The ALU decodes funct and shamt itself, so this block only needs the opcode.
  logic              unused_instr;
  assign unused_instr = ^Instr[25:0];

  assign opcode = Instr[31:26];

`ifdef MEMWAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // State, watchdog counter, sticky error and retired count; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
      retired_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
      if (err_set) err_reg <= 1'b1;
      if (retire)  retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  // Next-state dispatch and Moore output decode of the registered state.
  always_comb begin
    state_next     = state_reg;
    stall_cnt_next = stall_cnt_reg;
    err_set        = 1'b0;
    retire         = 1'b0;
    PcEn           = 1'b0;
    IorD           = 1'b0;
    IrWrite        = 1'b0;
    IrSel          = 1'b1;
    RegDst         = 1'b0;
    MemToReg       = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    ExtSel         = 1'b0;
    ALUsel         = 1'b0;
    PCSrc          = 1'b0;
    ALUSrcB        = 2'b00;
    ALUControl     = ALU_ADD;
    MemWrite       = 1'b0;
    unique case (state_reg)
      FETCH: begin
        IrSel   = 1'b0;
        ALUSrcB = 2'b01;
        IrWrite = mem_rdy;
        PcEn    = mem_rdy;
        if (mem_rdy) state_next = DECODE;
      end
      DECODE: begin
        // PC + (imm << 2) is computed here as the branch target.
        ALUSrcB = 2'b11;
        unique case (opcode)
          OP_RTYPE:                 state_next = EXEC_R;
          OP_ADDIU, OP_ANDI, OP_ORI: state_next = EXEC_I;
          OP_LW, OP_SW:             state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:           state_next = BRANCH;
          OP_J:                     state_next = JUMP;
          default: begin
            state_next = FETCH;
            err_set    = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_FUNCT;
        if (stall) begin
          if (stall_cnt_reg == STALL_LAST) begin
            // The ALU has been busy too long, so abandon the instruction.
            err_set        = 1'b1;
            stall_cnt_next = '0;
            state_next     = FETCH;
          end else begin
            stall_cnt_next = stall_cnt_reg + SC_W'(1);
          end
        end else begin
          stall_cnt_next = '0;
          state_next     = ALU_WB_R;
        end
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_ANDI) begin
          ALUControl = ALU_AND;
          ExtSel     = 1'b1;
        end else if (opcode == OP_ORI) begin
          ALUControl = ALU_OR;
          ExtSel     = 1'b1;
        end
        state_next = ALU_WB_I;
      end
      ALU_WB_R, ALU_WB_I: begin
        RegDst     = (state_reg == ALU_WB_R);
        MemToReg   = 1'b1;
        ALUsel     = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        IorD   = 1'b1;
        ALUsel = 1'b1;
        if (mem_rdy) state_next = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        IorD     = 1'b1;
        ALUsel   = 1'b1;
        MemWrite = mem_rdy;
        if (mem_rdy) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        ALUsel     = 1'b1;
        PCSrc      = 1'b1;
        PcEn       = (opcode == OP_BNE) ? ~zero : zero;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        ALUSrcB    = 2'b11;
        PcEn       = 1'b1;
        PCSrc      = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  assign err     = err_reg;
  assign retired = retired_reg;

endmodule
